ram_responder: RTL and testbench



---
 rtl/ram_responder.sv | 188 ++++++++++++++++++
 tb/tb_ram_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// RAM-port responder: accepts one read or lane-masked write, holds it for WAIT_CYCLES, then responds.
// Define RAM_RESPONDER_ERR_EN to add the err_o strobe for out-of-range, read+write and empty-mask accesses.
module ram_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] addr_i,
    input  logic        read_en_i,
    input  logic        write_en_i,
    input  logic [3:0]  byte_en_i,
    input  logic [31:0] writedata_i,
    output logic        waitrequest_o,
    output logic [31:0] readdata_o,
`ifdef RAM_RESPONDER_ERR_EN
    output logic        readdata_valid_o,
    output logic        err_o
`else
    output logic        readdata_valid_o
`endif
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;

    logic [AW-1:0]  idx_q;
    logic           in_range_q;
    logic           wr_q;
    logic           rd_q;
    logic [3:0]     be_q;
    logic [31:0]    wd_q;

    logic [31:0]    mem [DEPTH];

    logic [29:0]    word_off;
    logic           req_in_range;
    logic           accept;
    logic           enter_resp;

    logic [AW-1:0]  eff_idx;
    logic           eff_in_range;
    logic           eff_wr;
    logic           eff_rd;
    logic [3:0]     eff_be;
    logic [31:0]    eff_wd;

    logic           unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr_i[1:0]};

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign word_off     = addr_i[31:2] - BASE_ADDR[31:2];
    assign req_in_range = ((word_off >> AW) == '0);
    assign accept       = (state_q == IDLE) && (read_en_i || write_en_i);

    // With WAIT_CYCLES=0 RESP is entered on the acceptance edge, so the live inputs are used there.
    always_comb begin
        eff_idx      = idx_q;
        eff_in_range = in_range_q;
        eff_wr       = wr_q;
        eff_rd       = rd_q;
        eff_be       = be_q;
        eff_wd       = wd_q;
        if (accept) begin
            eff_idx      = word_off[AW-1:0];
            eff_in_range = req_in_range;
            eff_wr       = write_en_i;
            eff_rd       = read_en_i && !write_en_i;
            eff_be       = byte_en_i;
            eff_wd       = writedata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            be_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q      <= eff_idx;
                in_range_q <= eff_in_range;
                wr_q       <= eff_wr;
                rd_q       <= eff_rd;
                be_q       <= eff_be;
                wd_q       <= eff_wd;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            waitrequest_o    <= 1'b0;
            readdata_valid_o <= 1'b0;
            readdata_o       <= '0;
        end else begin
            waitrequest_o    <= (state_d != IDLE);
            readdata_valid_o <= enter_resp && eff_rd;
            if (enter_resp && eff_rd && eff_in_range) begin
                readdata_o <= mem[eff_idx] & lane_mask(eff_be);
            end else begin
                readdata_o <= '0;
            end
        end
    end

    // Storage is not reset; the rst_n_i gate keeps a write from landing while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && enter_resp && eff_wr && eff_in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (eff_be[b]) begin
                    mem[eff_idx][8*b +: 8] <= eff_wd[8*b +: 8];
                end
            end
        end
    end

`ifdef RAM_RESPONDER_ERR_EN
    logic err_q;
    logic eff_err;

    assign eff_err = accept ? (!req_in_range || (read_en_i && write_en_i) || (byte_en_i == 4'd0))
                            : err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (accept) begin
                err_q <= eff_err;
            end
            err_o <= enter_resp && eff_err;
        end
    end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench: two responders (WAIT_CYCLES=1 and 0) share one random stimulus stream,
// each compared cycle by cycle against a transaction-schedule model.
module tb_ram_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hBFC0_0000;
    localparam int          WS [2] = '{1, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr;
    logic [31:0] addr, wd;
    logic [3:0]  be;

    logic [1:0]  wreq_v;
    logic [1:0]  valid_v;
    logic [31:0] rdata_v [2];
`ifdef RAM_RESPONDER_ERR_EN
    logic [1:0]  err_v;
`endif

    always #5 clk = ~clk;

    ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut_w1 (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .read_en_i(rd), .write_en_i(wr),
        .byte_en_i(be), .writedata_i(wd), .waitrequest_o(wreq_v[0]),
        .readdata_o(rdata_v[0]),
`ifdef RAM_RESPONDER_ERR_EN
        .readdata_valid_o(valid_v[0]), .err_o(err_v[0])
`else
        .readdata_valid_o(valid_v[0])
`endif
    );

    ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_w0 (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .read_en_i(rd), .write_en_i(wr),
        .byte_en_i(be), .writedata_i(wd), .waitrequest_o(wreq_v[1]),
        .readdata_o(rdata_v[1]),
`ifdef RAM_RESPONDER_ERR_EN
        .readdata_valid_o(valid_v[1]), .err_o(err_v[1])
`else
        .readdata_valid_o(valid_v[1])
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: per instance a word array plus the schedule of the one outstanding access.
    int          edge_n;
    logic [31:0] mem_m [2][DEPTH];
    bit          has_txn [2];
    int          resp_edge [2];
    bit          t_wr [2], t_rd [2], t_inr [2], t_err [2];
    int          t_idx [2];
    logic [3:0]  t_be [2];
    logic [31:0] t_wd [2];
    bit          e_wreq [2], e_valid [2], e_err [2];
    logic [31:0] e_data [2];

    int          strobe_cnt [2];
    logic [31:0] last_rd [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at edge %0d", tag, obs, exp_v, edge_n);
        end
    endtask

    task automatic model_edge();
        logic [31:0] off;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            e_valid[i] = 1'b0;
            e_data[i]  = '0;
            e_err[i]   = 1'b0;
            if (!rst_n) begin
                has_txn[i] = 1'b0;
                e_wreq[i]  = 1'b0;
                continue;
            end
            // Accepted only once the previous access has been back in IDLE for a cycle.
            if ((rd || wr) && (!has_txn[i] || edge_n >= resp_edge[i] + 2)) begin
                off          = addr - BASE;
                t_inr[i]     = (off < 32'(4 * DEPTH));
                t_idx[i]     = t_inr[i] ? int'(off / 4) : 0;
                t_wr[i]      = wr;
                t_rd[i]      = rd && !wr;
                t_be[i]      = be;
                t_wd[i]      = wd;
                t_err[i]     = !t_inr[i] || (rd && wr) || (be == 4'd0);
                resp_edge[i] = edge_n + WS[i];
                has_txn[i]   = 1'b1;
            end
            if (has_txn[i] && edge_n == resp_edge[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (t_wr[i] && t_inr[i] && t_be[i][b])
                        mem_m[i][t_idx[i]][8*b +: 8] = t_wd[i][8*b +: 8];
                    if (t_rd[i] && t_inr[i] && t_be[i][b])
                        e_data[i][8*b +: 8] = mem_m[i][t_idx[i]][8*b +: 8];
                end
                e_valid[i] = t_rd[i];
                e_err[i]   = t_err[i];
            end
            e_wreq[i] = has_txn[i] && (edge_n <= resp_edge[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wreq%0d", i), 32'(wreq_v[i]), 32'(e_wreq[i]));
            check($sformatf("valid%0d", i), 32'(valid_v[i]), 32'(e_valid[i]));
            check($sformatf("rdata%0d", i), rdata_v[i], e_data[i]);
`ifdef RAM_RESPONDER_ERR_EN
            check($sformatf("err%0d", i), 32'(err_v[i]), 32'(e_err[i]));
`endif
            if (valid_v[i]) begin
                strobe_cnt[i]++;
                last_rd[i] = rdata_v[i];
            end
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        rd = r; wr = w; addr = a; be = b; wd = d;
        step();
        rd = 1'b0; wr = 1'b0;
        step();
        step();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            strobe_cnt[i] = 0;
            last_rd[i]    = 32'hFFFF_FFFF;
        end
    endtask

    initial begin
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wd = '0;
        edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            has_txn[i] = 1'b0; resp_edge[i] = 0;
        end
        clear_stats();

        step();
        step();
        rst_n = 1'b1;
        step();

        for (int k = 0; k < int'(DEPTH); k++)
            access(1'b0, 1'b1, BASE + 32'(4 * k), 4'hF, $urandom);

        // Word write and read-back
        clear_stats();
        access(1'b0, 1'b1, 32'hBFC0_0010, 4'hF, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'hBFC0_0010, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("word_rd%0d", i), last_rd[i], 32'hDEAD_BEEF);
            check($sformatf("word_cnt%0d", i), 32'(strobe_cnt[i]), 32'd1);
        end

        // Lane masking
        access(1'b0, 1'b1, 32'hBFC0_0020, 4'hF, 32'h1122_3344);
        access(1'b0, 1'b1, 32'hBFC0_0020, 4'hC, 32'hAABB_CCDD);
        access(1'b1, 1'b0, 32'hBFC0_0020, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++)
            check($sformatf("lane_full%0d", i), last_rd[i], 32'hAABB_3344);
        access(1'b1, 1'b0, 32'hBFC0_0020, 4'h8, 32'h0);
        for (int i = 0; i < 2; i++)
            check($sformatf("lane_top%0d", i), last_rd[i], 32'hAA00_0000);

        // Out-of-range write then read
        access(1'b0, 1'b1, 32'h0000_0000, 4'hF, 32'h5555_5555);
        clear_stats();
        access(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("oor_rd%0d", i), last_rd[i], 32'h0);
            check($sformatf("oor_cnt%0d", i), 32'(strobe_cnt[i]), 32'd1);
        end

        // Simultaneous read and write: write commits, no strobe
        clear_stats();
        access(1'b1, 1'b1, 32'hBFC0_0030, 4'hF, 32'h0F0F_0F0F);
        for (int i = 0; i < 2; i++)
            check($sformatf("rw_nostrobe%0d", i), 32'(strobe_cnt[i]), 32'd0);
        access(1'b1, 1'b0, 32'hBFC0_0030, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++)
            check($sformatf("rw_commit%0d", i), last_rd[i], 32'h0F0F_0F0F);

        // Continuous read requests: period 3 for one wait state, 2 for none
        clear_stats();
        rd = 1'b1; be = 4'hF;
        for (int c = 0; c < 24; c++) begin
            addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            step();
        end
        rd = 1'b0;
        check("busy_cnt_w1", 32'(strobe_cnt[0]), 32'd8);
        check("busy_cnt_w0", 32'(strobe_cnt[1]), 32'd12);
        step();
        step();

        // Reset during the wait state of a write
        access(1'b0, 1'b1, 32'hBFC0_0014, 4'hF, 32'h1234_5678);
        rd = 1'b0; wr = 1'b1; addr = 32'hBFC0_0014; be = 4'hF; wd = 32'hFFFF_0000;
        step();
        wr = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_wreq%0d", i), 32'(wreq_v[i]), 32'd0);
            check($sformatf("rst_valid%0d", i), 32'(valid_v[i]), 32'd0);
            check($sformatf("rst_rdata%0d", i), rdata_v[i], 32'd0);
            has_txn[i] = 1'b0;
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        access(1'b1, 1'b0, 32'hBFC0_0014, 4'hF, 32'h0);
        check("rst_word_w1", last_rd[0], 32'h1234_5678);
        check("rst_word_w0", last_rd[1], 32'hFFFF_0000);

        // Random traffic, including out-of-range, empty masks and busy-window requests
        for (int c = 0; c < 400; c++) begin
            int sel;
            sel  = int'($urandom_range(0, 9));
            rd   = ($urandom_range(0, 4) < 2);
            wr   = ($urandom_range(0, 4) < 2);
            if (sel == 0)
                addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else if (sel == 1)
                addr = BASE - 32'd4 - 32'($urandom_range(0, 255));
            else
                addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wd = $urandom;
            step();
        end
        rd = 1'b0; wr = 1'b0;
        for (int c = 0; c < 4; c++) step();

        // Final sweep: every word read back through both instances
        for (int k = 0; k < int'(DEPTH); k++)
            access(1'b1, 1'b0, BASE + 32'(4 * k), 4'hF, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
